// File: rtl/exu_pipe.sv
// Execute stage: single-cycle ALU, branch/jump redirect and iterative multiplier,
// with a valid/ready handshake on both sides and a registered result toward MEM.
module exu_pipe #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4,
  parameter int RADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [XLEN-1:0]    in_src2,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [3:0]         in_alu_op,
  input  logic [2:0]         in_bran,
  input  logic [1:0]         in_jump,
  input  logic               in_reg_wen,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_res,
  output logic [XLEN-1:0]    out_rs2,
  output logic               out_reg_wen,
  output logic [RADDR_W-1:0] out_rd,
  output logic               redir_valid,
  output logic [XLEN-1:0]    redir_pc
);
  // state | meaning
  // IDLE  | accepting ops; single-cycle results load the output regs directly
  // MUL   | accumulating MUL_STEP partial products per cycle
  // DONE  | multiply finished, waiting for the output regs to be free
  localparam int MUL_CYC = XLEN / MUL_STEP;
  localparam int SH_W    = $clog2(XLEN);
  localparam int CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [2*XLEN-1:0] ONE_W = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   ONE_X = XLEN'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2*XLEN-1:0]  mcand, acc, prod;
  logic [XLEN-1:0]    mplier, mag1, mag2, alu_res, target;
  logic [CNT_W-1:0]   cnt;
  logic               neg, hi_sel, p_wen;
  logic [XLEN-1:0]    p_rs2;
  logic [RADDR_W-1:0] p_rd;
  logic               is_mul, is_mulh, out_free, accept, taken, redirect;
  logic [SH_W-1:0]    shamt;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready && !flush;
  assign is_mul   = (in_alu_op == 4'd10) || (in_alu_op == 4'd11) || (in_alu_op == 4'd12);
  assign is_mulh  = (in_alu_op == 4'd11);
  assign shamt    = in_src2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (in_alu_op)
      4'd0:  alu_res = in_src1 + in_src2;
      4'd1:  alu_res = in_src1 - in_src2;
      4'd2:  alu_res = in_src1 << shamt;
      4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_src1) < $signed(in_src2)};
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, in_src1 < in_src2};
      4'd5:  alu_res = in_src1 ^ in_src2;
      4'd6:  alu_res = in_src1 >> shamt;
      4'd7:  alu_res = $unsigned($signed(in_src1) >>> shamt);
      4'd8:  alu_res = in_src1 | in_src2;
      4'd9:  alu_res = in_src1 & in_src2;
      4'd13: alu_res = in_src2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (in_bran)
      3'd1: taken = (in_src1 == in_rs2);
      3'd2: taken = (in_src1 != in_rs2);
      3'd3: taken = $signed(in_src1) < $signed(in_rs2);
      3'd4: taken = $signed(in_src1) >= $signed(in_rs2);
      3'd5: taken = in_src1 < in_rs2;
      3'd6: taken = in_src1 >= in_rs2;
      default: taken = 1'b0;
    endcase
  end

  assign redirect = !is_mul && (taken || (in_jump != 2'd0));
  assign target   = (in_jump == 2'd2) ? ((in_src1 + in_imm) & ~ONE_X) : (in_pc + in_imm);

  // MULH works on magnitudes; the sign is reapplied to the full product at the end
  assign mag1 = (is_mulh && in_src1[XLEN-1]) ? (~in_src1 + ONE_X) : in_src1;
  assign mag2 = (is_mulh && in_src2[XLEN-1]) ? (~in_src2 + ONE_X) : in_src2;
  assign prod = neg ? (~acc + ONE_W) : acc;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:  if (cnt == CNT_W'(MUL_CYC-1)) state_nxt = S_DONE;
      S_DONE: if (out_free) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_sel <= 1'b0;
      p_rs2  <= '0;
      p_wen  <= 1'b0;
      p_rd   <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{XLEN{1'b0}}, mag1};
      mplier <= mag2;
      acc    <= '0;
      cnt    <= '0;
      neg    <= is_mulh && (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
      hi_sel <= (in_alu_op != 4'd10);
      p_rs2  <= in_rs2;
      p_wen  <= in_reg_wen;
      p_rd   <= in_rd;
    end else if (state == S_MUL) begin
      acc    <= acc + mcand * {{(2*XLEN-MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_rs2     <= '0;
      out_reg_wen <= 1'b0;
      out_rd      <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      redir_valid <= 1'b0;
    end else begin
      redir_valid <= accept && redirect;
      if (accept && redirect) redir_pc <= target;
      if (accept && !is_mul) begin
        out_valid   <= 1'b1;
        out_res     <= (in_jump != 2'd0) ? (in_pc + XLEN'(4)) : alu_res;
        out_rs2     <= in_rs2;
        out_reg_wen <= in_reg_wen;
        out_rd      <= in_rd;
      end else if (state == S_DONE && out_free) begin
        out_valid   <= 1'b1;
        out_res     <= hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        out_rs2     <= p_rs2;
        out_reg_wen <= p_wen;
        out_rd      <= p_rd;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exu_pipe.sv
// Directed bench for exu_pipe: vector table for single-cycle ops and redirects,
// hand-written sequences for multiply latency, backpressure, flush and reset.
module tb_exu_pipe;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_src1, in_src2, in_rs2, in_imm;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_bran;
  logic [1:0]  in_jump;
  logic        in_reg_wen;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_reg_wen, redir_valid;
  logic [31:0] out_res, out_rs2, redir_pc;
  logic [4:0]  out_rd;

  int n_vec = 0;
  int n_err = 0;

  exu_pipe #(.XLEN(32), .MUL_STEP(4), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_bran(in_bran), .in_jump(in_jump),
    .in_reg_wen(in_reg_wen), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rs2(out_rs2),
    .out_reg_wen(out_reg_wen), .out_rd(out_rd),
    .redir_valid(redir_valid), .redir_pc(redir_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  bran;
    logic [1:0]  jump;
    logic [31:0] pc, s1, s2, rs2, imm;
    logic        chk_res;
    logic [31:0] res;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic [3:0] op, logic [2:0] bran, logic [1:0] jump,
                              logic [31:0] pc, logic [31:0] s1, logic [31:0] s2,
                              logic [31:0] rs2, logic [31:0] imm, logic chk_res,
                              logic [31:0] res, logic redir, logic [31:0] rpc);
    vec_t v;
    v.op = op; v.bran = bran; v.jump = jump; v.pc = pc; v.s1 = s1; v.s2 = s2;
    v.rs2 = rs2; v.imm = imm; v.chk_res = chk_res; v.res = res; v.redir = redir; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] bran, input logic [1:0] jump,
                       input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] rs2, input logic [31:0] imm);
    in_alu_op = op; in_bran = bran; in_jump = jump; in_pc = pc;
    in_src1 = s1; in_src2 = s2; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic run_mul(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    drive(op, 3'd0, 2'd0, 32'h0, a, b, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, " in_ready busy"}, {31'b0, in_ready}, 32'd0);
    chk({nm, " no redir"}, {31'b0, redir_valid}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, 32'd9);
    chk({nm, " res"}, out_res, exp);
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_reg_wen = 1'b1; in_rd = 5'd3;
    drive(4'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    in_valid = 1'b0;

    vecs[0]  = mk(4'd0,  3'd0, 2'd0, 32'h0,   32'd5,        32'd7,     32'h0,        32'h0,        1, 32'd12,       0, 32'h0);
    vecs[1]  = mk(4'd1,  3'd0, 2'd0, 32'h0,   32'd5,        32'd7,     32'h0,        32'h0,        1, 32'hFFFFFFFE, 0, 32'h0);
    vecs[2]  = mk(4'd2,  3'd0, 2'd0, 32'h0,   32'd1,        32'h24,    32'h0,        32'h0,        1, 32'h10,       0, 32'h0);
    vecs[3]  = mk(4'd3,  3'd0, 2'd0, 32'h0,   32'hFFFFFFFF, 32'd1,     32'h0,        32'h0,        1, 32'd1,        0, 32'h0);
    vecs[4]  = mk(4'd4,  3'd0, 2'd0, 32'h0,   32'hFFFFFFFF, 32'd1,     32'h0,        32'h0,        1, 32'd0,        0, 32'h0);
    vecs[5]  = mk(4'd5,  3'd0, 2'd0, 32'h0,   32'hF0,       32'hFF,    32'h0,        32'h0,        1, 32'h0F,       0, 32'h0);
    vecs[6]  = mk(4'd6,  3'd0, 2'd0, 32'h0,   32'h80000000, 32'd4,     32'h0,        32'h0,        1, 32'h08000000, 0, 32'h0);
    vecs[7]  = mk(4'd7,  3'd0, 2'd0, 32'h0,   32'h80000000, 32'd4,     32'h0,        32'h0,        1, 32'hF8000000, 0, 32'h0);
    vecs[8]  = mk(4'd8,  3'd0, 2'd0, 32'h0,   32'hF0,       32'h0F,    32'h0,        32'h0,        1, 32'hFF,       0, 32'h0);
    vecs[9]  = mk(4'd9,  3'd0, 2'd0, 32'h0,   32'hF0,       32'h3C,    32'h0,        32'h0,        1, 32'h30,       0, 32'h0);
    vecs[10] = mk(4'd13, 3'd0, 2'd0, 32'h0,   32'hDEAD,     32'h1234,  32'h0,        32'h0,        1, 32'h1234,     0, 32'h0);
    vecs[11] = mk(4'd0,  3'd1, 2'd0, 32'h100, 32'd9,        32'd9,     32'd9,        32'h20,       0, 32'h0,        1, 32'h120);
    vecs[12] = mk(4'd0,  3'd2, 2'd0, 32'h100, 32'd9,        32'd9,     32'd9,        32'h20,       0, 32'h0,        0, 32'h0);
    vecs[13] = mk(4'd0,  3'd3, 2'd0, 32'h200, 32'hFFFFFFFF, 32'd0,     32'd1,        32'hFFFFFFF8, 0, 32'h0,        1, 32'h1F8);
    vecs[14] = mk(4'd0,  3'd6, 2'd0, 32'h200, 32'd1,        32'd0,     32'hFFFFFFFF, 32'h8,        0, 32'h0,        0, 32'h0);
    vecs[15] = mk(4'd0,  3'd0, 2'd1, 32'h40,  32'h0,        32'h0,     32'h0,        32'h100,      1, 32'h44,       1, 32'h140);
    vecs[16] = mk(4'd0,  3'd0, 2'd2, 32'h40,  32'h203,      32'h0,     32'h0,        32'h0,        1, 32'h44,       1, 32'h202);
    vecs[17] = mk(4'd0,  3'd4, 2'd0, 32'h300, 32'd5,        32'd0,     32'd5,        32'h10,       0, 32'h0,        1, 32'h310);

    #12;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst redir_valid", {31'b0, redir_valid}, 32'd0);
    chk("rst out_res", out_res, 32'd0);
    chk("rst redir_pc", redir_pc, 32'd0);
    chk("rst out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst out_reg_wen", {31'b0, out_reg_wen}, 32'd0);
    rst_n = 1'b1;

    // back-to-back single-cycle ops with out_ready held high
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].bran, vecs[i].jump, vecs[i].pc, vecs[i].s1,
            vecs[i].s2, vecs[i].rs2, vecs[i].imm);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      if (vecs[i].chk_res) chk($sformatf("v%0d out_res", i), out_res, vecs[i].res);
      chk($sformatf("v%0d redir_valid", i), {31'b0, redir_valid}, {31'b0, vecs[i].redir});
      if (vecs[i].redir) chk($sformatf("v%0d redir_pc", i), redir_pc, vecs[i].rpc);
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    @(negedge clk);
    chk("redir pulse ends", {31'b0, redir_valid}, 32'd0);
    chk("out_valid drains", {31'b0, out_valid}, 32'd0);

    run_mul("MULH", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    run_mul("MULHU", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mul("MUL", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    run_mul("MULH mixed", 4'd11, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    run_mul("MUL small", 4'd10, 32'd1234, 32'd5678, 32'd7006652);

    // backpressure holds the result and blocks new ops
    @(negedge clk);
    out_ready = 1'b0;
    in_rd = 5'd9;
    drive(4'd0, 3'd0, 2'd0, 32'h0, 32'd3, 32'd4, 32'hAB, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d out_res", k), out_res, 32'd7);
      chk($sformatf("bp%0d in_ready", k), {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp out_rd", {27'b0, out_rd}, 32'd9);
    chk("bp out_rs2", out_rs2, 32'hAB);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);

    // flush during multiply abandons it
    drive(4'd10, 3'd0, 2'd0, 32'h0, 32'd6, 32'd7, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush mul in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush mul no out_valid", {31'b0, seen}, 32'd0);

    // op offered in the flush cycle is dropped, including its redirect
    drive(4'd0, 3'd0, 2'd1, 32'h40, 32'h0, 32'h0, 32'h0, 32'h100);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush drop out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush drop redir", {31'b0, redir_valid}, 32'd0);

    // reset in the middle of a multiply
    drive(4'd12, 3'd0, 2'd0, 32'h0, 32'd9, 32'd9, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst mid-mul in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst mid-mul no out_valid", {31'b0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
